// File: rtl/feynman_cascade_sequencer.sv
// feynman_cascade_sequencer: runs a stored program of CNOT (Feynman) ops over a WIDTH-bit state, one op per clock
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   op_valid/op_ctrl/op_tgt    append an op {ctrl, tgt} to the program buffer
//   op_ready                   buffer can take an op this cycle (IDLE and not full)
//   prog_clear                 empty the program buffer (IDLE only)
//   op_count                   number of ops loaded
//   start/reverse/data_in      launch a run, forward or last-to-first, from data_in
//   data_out                   working state register
//   busy/done/err              running, one-cycle completion pulse, sticky illegal-op flag
module feynman_cascade_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int IDXW = $clog2(WIDTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [IDXW-1:0]  op_ctrl,
    input  logic [IDXW-1:0]  op_tgt,
    output logic             op_ready,
    input  logic             prog_clear,
    output logic [CW-1:0]    op_count,
    input  logic             start,
    input  logic             reverse,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDXW:0] WL = (IDXW + 1)'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     pc_q, pc_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              err_q, err_d;
    logic              rev_q, rev_d;
    logic              wr_en;
    logic [2*IDXW-1:0] prog_q [DEPTH];
    logic [2*IDXW-1:0] cur_op;
    logic [IDXW-1:0]   ctrl, tgt;
    logic              illegal, last;

    assign cur_op  = prog_q[pc_q[AW-1:0]];
    assign ctrl    = cur_op[2*IDXW-1:IDXW];
    assign tgt     = cur_op[IDXW-1:0];
    // Index range checks only matter when WIDTH is not a power of two
    assign illegal = (ctrl == tgt) || ({1'b0, ctrl} >= WL) || ({1'b0, tgt} >= WL);
    assign last    = rev_q ? (pc_q == '0) : (pc_q == count_q - CW'(1));

    assign op_ready = (state_q == IDLE) && (count_q < CW'(DEPTH));
    assign op_count = count_q;
    assign data_out = data_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign err      = err_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pc_d    = pc_q;
        data_d  = data_q;
        err_d   = err_q;
        rev_d   = rev_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (prog_clear) begin
                    count_d = '0;
                end else begin
                    // An op accepted alongside start is appended first and joins the run
                    if (op_valid && op_ready) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                    if (start) begin
                        data_d  = data_in;
                        err_d   = 1'b0;
                        rev_d   = reverse;
                        pc_d    = reverse ? count_d - CW'(1) : '0;
                        state_d = (count_d == '0) ? DONE : RUN;
                    end
                end
            end
            RUN: begin
                if (illegal) err_d = 1'b1;
                else data_d[tgt] = data_q[tgt] ^ data_q[ctrl];
                if (last) state_d = DONE;
                else pc_d = rev_q ? pc_q - CW'(1) : pc_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            pc_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            rev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            err_q   <= err_d;
            rev_q   <= rev_d;
        end
    end

    // Program storage needs no reset: only entries below op_count are ever read
    always_ff @(posedge clk) begin
        if (wr_en) prog_q[count_q[AW-1:0]] <= {op_ctrl, op_tgt};
    end
endmodule

// File: tb/tb_feynman_cascade_sequencer.sv
// tb_feynman_cascade_sequencer: directed bench with a program-level reference model checked every cycle
module tb_feynman_cascade_sequencer;
    logic       clk = 0, rst = 1, op_valid = 0, prog_clear = 0, start = 0, reverse = 0;
    logic [2:0] op_ctrl = 0, op_tgt = 0;
    logic [7:0] data_in = 0;
    logic       op_ready, busy, done, err;
    logic [4:0] op_count;
    logic [7:0] data_out;
    int         n_chk = 0, n_fail = 0;
    bit         chk_en = 0;
    int         lat, nb;

    feynman_cascade_sequencer #(.WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ctrl(op_ctrl), .op_tgt(op_tgt),
        .op_ready(op_ready), .prog_clear(prog_clear), .op_count(op_count), .start(start),
        .reverse(reverse), .data_in(data_in), .data_out(data_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: program kept as lists of (ctrl,tgt); a run's result is computed at once
    // and the model just counts down the cycles the run occupies.
    int         mc[$], mt[$];
    logic [7:0] m_data = 0;
    int         m_left = 0, idx;
    bit         m_done = 0, m_err = 0;

    always @(posedge clk) begin
        if (rst) begin
            mc.delete(); mt.delete();
            m_data = 0; m_left = 0; m_done = 0; m_err = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
        end else if (m_done) begin
            m_done = 0;
        end else if (prog_clear) begin
            mc.delete(); mt.delete();
        end else begin
            if (op_valid && mc.size() < 16) begin
                mc.push_back(int'(op_ctrl));
                mt.push_back(int'(op_tgt));
            end
            if (start) begin
                m_data = data_in;
                m_err = 0;
                for (int k = 0; k < mc.size(); k++) begin
                    idx = reverse ? mc.size() - 1 - k : k;
                    if (mc[idx] == mt[idx] || mc[idx] >= 8 || mt[idx] >= 8) m_err = 1;
                    else m_data[mt[idx]] = m_data[mt[idx]] ^ m_data[mc[idx]];
                end
                m_left = mc.size();
                m_done = (m_left == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_left > 0);
            chk("done", done, m_done);
            chk("op_count", op_count, mc.size());
            chk("op_ready", op_ready, m_left == 0 && !m_done && mc.size() < 16);
            if (m_left == 0) begin
                chk("data_out", data_out, m_data);
                chk("err", err, m_err);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input int c, input int t);
        op_valid = 1; op_ctrl = 3'(c); op_tgt = 3'(t);
        tick();
        op_valid = 0;
    endtask

    task automatic wait_done(output int l, output int b);
        l = 1; b = 0;
        while (!done && l < 200) begin
            if (busy) b++;
            tick();
            l++;
        end
        if (!done) chk("run_timeout", done, 1);
    endtask

    // Returns with data_out holding the result, in the cycle right after done
    task automatic run(input logic [7:0] din, input logic rev, output int l, output int b);
        start = 1; data_in = din; reverse = rev;
        tick();
        start = 0; op_valid = 0;
        wait_done(l, b);
        tick();
    endtask

    initial begin
        logic [7:0] t1_exp [4];
        t1_exp = '{8'h00, 8'h03, 8'h02, 8'h01};
        tick();
        chk_en = 1;
        rst = 0;
        chk("reset_data", data_out, 8'h00);
        chk("reset_count", op_count, 0);
        chk("reset_ready", op_ready, 1);
        chk("reset_busy", busy, 0);

        load(0, 1);
        for (int i = 0; i < 4; i++) begin
            run(8'(i), 0, lat, nb);
            chk("t1_data", data_out, t1_exp[i]);
            chk("t1_latency", lat, 2);
        end

        prog_clear = 1; tick(); prog_clear = 0;
        load(0, 1); load(1, 0); load(0, 1);
        run(8'hA1, 0, lat, nb);
        chk("t2_fwd_data", data_out, 8'hA2);
        chk("t2_fwd_latency", lat, 4);
        chk("t2_fwd_busy", nb, 3);
        run(8'hA2, 1, lat, nb);
        chk("t2_rev_data", data_out, 8'hA1);
        chk("t2_rev_busy", nb, 3);

        prog_clear = 1; tick(); prog_clear = 0;
        load(3, 3); load(2, 5);
        run(8'h04, 0, lat, nb);
        chk("t3_err", err, 1);
        chk("t3_data", data_out, 8'h24);
        prog_clear = 1; tick(); prog_clear = 0;
        load(0, 7);
        run(8'h01, 0, lat, nb);
        chk("t3_err_clear", err, 0);
        chk("t3_data2", data_out, 8'h81);

        prog_clear = 1; tick(); prog_clear = 0;
        for (int i = 0; i < 16; i++) load(i % 8, (i + 1) % 8);
        chk("t4_full_count", op_count, 16);
        chk("t4_full_ready", op_ready, 0);
        load(1, 2);
        chk("t4_overflow_count", op_count, 16);
        prog_clear = 1; tick(); prog_clear = 0;
        chk("t4_clear_count", op_count, 0);
        chk("t4_clear_ready", op_ready, 1);
        run(8'h5A, 0, lat, nb);
        chk("t4_empty_latency", lat, 1);
        chk("t4_empty_data", data_out, 8'h5A);

        for (int i = 0; i < 10; i++) load(i % 8, (i + 3) % 8);
        start = 1; data_in = 8'h3C; reverse = 0;
        tick();
        start = 0;
        tick(); tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        chk("t5_data", data_out, 8'h00);
        chk("t5_busy", busy, 0);
        chk("t5_count", op_count, 0);
        for (int i = 0; i < 12; i++) begin
            chk("t5_no_done", done, 0);
            tick();
        end

        load(0, 1); load(1, 2); load(2, 3);
        run(8'h01, 0, lat, nb);
        chk("t6_clean_data", data_out, 8'h0F);
        start = 1; data_in = 8'h01; reverse = 0;
        tick();
        start = 1; op_valid = 1; prog_clear = 1; op_ctrl = 5; op_tgt = 6;
        tick();
        start = 0; op_valid = 0; prog_clear = 0;
        wait_done(lat, nb);
        tick();
        chk("t6_disturbed_count", op_count, 3);
        chk("t6_disturbed_data", data_out, 8'h0F);
        op_valid = 1; op_ctrl = 3; op_tgt = 4;
        run(8'h01, 0, lat, nb);
        chk("t6_append_count", op_count, 4);
        chk("t6_append_data", data_out, 8'h1F);
        chk("t6_append_latency", lat, 5);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end
endmodule
